dino_collision_score: RTL



---
 rtl/dino_collision_score.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dino_collision_score.sv
// Game-rule stage: samples dino/danger state on each game tick, tests bounding-box
// overlap through a two-stage pipeline, latches game-over and keeps BCD score/high score.
module dino_collision_score #(
  parameter int DINO_X    = 40,
  parameter int DINO_W    = 40,
  parameter int DINO_H    = 43,
  parameter int DANGER_W  = 24,
  parameter int CACTUS_H  = 48,
  parameter int BIRD_ALT  = 50,
  parameter int BIRD_H    = 24,
  parameter int SCORE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clk,
  input  logic        restart,
  input  logic [8:0]  dino_pos,
  input  logic [8:0]  danger_pos1,
  input  logic [8:0]  danger_pos2,
  input  logic [8:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        game_over,
  output logic [2:0]  hit_mask,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  typedef enum logic {RUN, OVER} state_t;

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);

  localparam logic [9:0] X_LO = 10'(DINO_X);
  localparam logic [9:0] X_HI = 10'(DINO_X + DINO_W);
  localparam logic [9:0] DW   = 10'(DANGER_W);
  localparam logic [9:0] DH   = 10'(DINO_H);
  localparam logic [9:0] C_HI = 10'(CACTUS_H);
  localparam logic [9:0] B_LO = 10'(BIRD_ALT);
  localparam logic [9:0] B_HI = 10'(BIRD_ALT + BIRD_H);

  state_t           state, state_nxt;
  logic             enter_over, leave_over;
  logic             gc_d, tick;
  logic [DIV_W-1:0] div_cnt;

  logic             s1_valid;
  logic [8:0]       s1_dino;
  logic [8:0]       s1_pos [3];
  logic [2:0]       s1_bird;
  logic [2:0]       s1_en;
  logic [2:0]       hit_c;

  logic             s2_valid;
  logic [2:0]       s2_hit;

  // Only the bird flag of the danger type matters to the geometry.
  logic unused_type;
  assign unused_type = ^{danger_type1[1:0], danger_type2[1:0], danger_type3[1:0]};

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Half-open spans on both axes, so boxes that merely touch do not collide.
  function automatic logic slot_hit(input logic en, input logic [8:0] pos,
                                    input logic bird, input logic [8:0] dino);
    logic [9:0] p, a_lo, a_hi, b_lo, b_hi;
    logic       h, v;
    p    = {1'b0, pos};
    a_lo = {1'b0, dino};
    a_hi = a_lo + DH;
    b_lo = bird ? B_LO : 10'd0;
    b_hi = bird ? B_HI : C_HI;
    h    = (p < X_HI) && ((p + DW) > X_LO);
    v    = (a_lo < b_hi) && (b_lo < a_hi);
    return en & h & v;
  endfunction

  assign tick      = game_clk & ~gc_d;
  assign game_over = (state == OVER);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit_c[i] = slot_hit(s1_en[i], s1_pos[i], s1_bird[i], s1_dino);
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_over = 1'b0;
    leave_over = 1'b0;
    case (state)
      RUN: begin
        if (s2_valid && (s2_hit != 3'b000)) begin
          state_nxt  = OVER;
          enter_over = 1'b1;
        end
      end
      OVER: begin
        if (restart) begin
          state_nxt  = RUN;
          leave_over = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      gc_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      gc_d  <= game_clk;
    end
  end

  // Restart flushes both stages so hits sampled during OVER never end the new game.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dino  <= '0;
      s1_pos   <= '{default: '0};
      s1_bird  <= '0;
      s1_en    <= '0;
      s2_valid <= 1'b0;
      s2_hit   <= '0;
    end else begin
      if (tick) begin
        s1_dino <= dino_pos;
        s1_pos  <= '{danger_pos1, danger_pos2, danger_pos3};
        s1_bird <= {danger_type3[2], danger_type2[2], danger_type1[2]};
        s1_en   <= {danger_en3, danger_en2, danger_en1};
      end
      s2_hit <= hit_c;
      if (leave_over) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= tick;
        s2_valid <= s1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score    <= 16'h0000;
      hi_score <= 16'h0000;
      hit_mask <= 3'b000;
      div_cnt  <= '0;
    end else begin
      if (leave_over) begin
        score    <= 16'h0000;
        div_cnt  <= '0;
        hit_mask <= 3'b000;
      end else begin
        if ((state == RUN) && tick) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            score   <= bcd_inc(score);
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        if (enter_over) begin
          hit_mask <= s2_hit;
          if (score > hi_score) begin
            hi_score <= score;
          end
        end
      end
    end
  end

endmodule
